// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned IMEM_DEPTH   = 128;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO; the head slot is a register so it drives outputs directly.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  fetch_entry_t wdata_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         head_valid_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_entry_t     slot0_q, slot0_d;
    fetch_entry_t     slot1_q, slot1_d;
    logic             vld0_q, vld0_d;
    logic             vld1_q, vld1_d;
    logic [CNT_W-1:0] count;
    logic             pop;

    assign count        = CNT_W'(vld0_q) + CNT_W'(vld1_q);
    assign full_o       = (count == CNT_W'(BUF_DEPTH));
    assign empty_o      = (count == '0);
    assign head_o       = slot0_q;
    assign head_valid_o = vld0_q;
    assign pop          = pop_i & vld0_q;

    // Pop shifts slot1 forward first, then a push fills the first free slot.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        vld0_d  = vld0_q;
        vld1_d  = vld1_q;
        if (pop) begin
            slot0_d = slot1_q;
            vld0_d  = vld1_q;
            vld1_d  = 1'b0;
        end
        if (push_i) begin
            if (!vld0_d) begin
                slot0_d = wdata_i;
                vld0_d  = 1'b1;
            end else if (!vld1_d) begin
                slot1_d = wdata_i;
                vld1_d  = 1'b1;
            end
        end
        if (flush_i) begin
            vld0_d = 1'b0;
            vld1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC / imem address, feeds a 2-entry
// prefetch buffer and handles start, stop/drain, redirect, wrap and faults.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = IMEM_DEPTH,
    parameter int unsigned ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned DATA_W    = FETCH_DATA_W,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy,
    output logic              fault
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;

    logic              push, pop, flush;
    logic              buf_full, buf_empty;
    fetch_entry_t      wr_entry, head;

    logic              start_ok, redir_ok;
    logic [ADDR_W-1:0] pc_inc;

    assign start_ok = (start_addr < ADDR_W'(DEPTH));
    assign redir_ok = (redirect_addr < ADDR_W'(DEPTH));
    assign pc_inc   = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);

    assign wr_entry  = '{pc: pc_q, instr: imem_data};
    assign imem_addr = pc_q;
    assign out_valid = pop_valid_head();
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign busy      = busy_q;
    assign fault     = fault_q;

    logic head_valid;
    function automatic logic pop_valid_head();
        return head_valid;
    endfunction

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (push),
        .wdata_i      (wr_entry),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_o       (head),
        .head_valid_o (head_valid),
        .full_o       (buf_full),
        .empty_o      (buf_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect beats stop inside FETCH/DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = start_ok ? ST_FETCH : ST_FAULT;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    state_d = redir_ok ? ST_FETCH : ST_FAULT;
                end else if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    state_d = redir_ok ? ST_FETCH : ST_FAULT;
                end else if (buf_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath controls and registered-status next values.
    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = head_valid & out_ready;
        flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && start_ok) begin
                    pc_d = start_addr;
                end
            end
            ST_FETCH, ST_DRAIN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redir_ok) begin
                        pc_d = redirect_addr;
                    end
                end else if (state_q == ST_FETCH && !stop && (!buf_full || pop)) begin
                    push = 1'b1;
                    pc_d = pc_inc;
                end
            end
            ST_FAULT: flush = 1'b1;
            default:  flush = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table of start cases plus
// hand-written backpressure, redirect, fault, stop and reset sequences.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] start_addr;
    logic        stop;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
    logic        fault;

    int checks = 0;
    int errors = 0;
    fetch_entry_t sb_q[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_addr     (start_addr),
        .stop           (stop),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy),
        .fault          (fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'hA00000AA;
        if (a < 32'd10) return {a[3:0], 20'h0, a[3:0], a[3:0]};
        return 32'hC000_0000 | a;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare a handshake about to complete at the next edge against the scoreboard.
    task automatic sb_check();
        fetch_entry_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pc %0h instr %0h expected no output", out_pc, out_instr);
        end else begin
            e = sb_q.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr) begin
                errors++;
                $display("FAIL sb_data: got pc %0h instr %0h expected pc %0h instr %0h",
                         out_pc, out_instr, e.pc, e.instr);
            end
        end
    endtask

    task automatic cycle();
        if (out_valid && out_ready) sb_check();
        @(negedge clk);
    endtask

    task automatic expect_stream(input logic [31:0] a, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = (a + 32'(i)) % 32'd128;
            e.instr = mem_word(e.pc);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        out_ready = 1'b1;
        while (sb_q.size() > 0 && used < budget) begin
            cycle();
            used++;
        end
        out_ready = 1'b0;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; start_addr = '0; stop = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic do_start(input logic [31:0] a);
        start = 1'b1; start_addr = a;
        cycle();
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          n_words;
        logic        exp_fault;
        logic [31:0] exp_first_instr;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int used;

        vecs[0] = '{32'd0,   3, 1'b0, 32'hA00000AA};
        vecs[1] = '{32'd5,   2, 1'b0, 32'h50000055};
        vecs[2] = '{32'd126, 4, 1'b0, 32'hC000007E};
        vecs[3] = '{32'd9,   3, 1'b0, 32'h90000099};
        vecs[4] = '{32'd200, 0, 1'b1, 32'h0};
        vecs[5] = '{32'd128, 0, 1'b1, 32'h0};

        reset_n = 1'b0;
        start = 1'b0; start_addr = '0; stop = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b0;
        @(negedge clk);
        do_reset();
        chk_reset_state("reset");

        // Start cases: latency, first word, wrap and throughput.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            do_start(vecs[i].addr);
            if (vecs[i].exp_fault) begin
                chk("vec_fault", 32'(fault), 32'd1);
                chk("vec_fault_busy", 32'(busy), 32'd1);
                cycle();
                chk("vec_fault_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("vec_lat_valid0", 32'(out_valid), 32'd0);
                chk("vec_busy", 32'(busy), 32'd1);
                cycle();
                chk("vec_lat_valid1", 32'(out_valid), 32'd1);
                chk("vec_first_pc", out_pc, vecs[i].addr);
                chk("vec_first_instr", out_instr, vecs[i].exp_first_instr);
                expect_stream(vecs[i].addr, vecs[i].n_words);
                drain(vecs[i].n_words + 8, used);
                chk("vec_throughput", 32'(used), 32'(vecs[i].n_words));
            end
        end

        // Backpressure: buffer saturates, head stable, then gapless release.
        do_reset();
        do_start(32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_pc_stable", out_pc, 32'd0);
            chk("bp_instr_stable", out_instr, 32'hA00000AA);
        end
        chk("bp_pc_hold", imem_addr, 32'd2);
        expect_stream(32'd0, 4);
        drain(12, used);
        chk("bp_gapless", 32'(used), 32'd4);

        // Redirect with a handshake in the redirect cycle.
        do_reset();
        do_start(32'd0);
        cycle();
        expect_stream(32'd0, 2);
        drain(8, used);
        expect_stream(32'd2, 1);
        redirect_valid = 1'b1; redirect_addr = 32'd7; out_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0; out_ready = 1'b0;
        chk("redir_flush", 32'(out_valid), 32'd0);
        chk("redir_pc", imem_addr, 32'd7);
        chk("redir_consumed", 32'(sb_q.size()), 32'd0);
        expect_stream(32'd7, 2);
        drain(8, used);
        chk("redir_latency", 32'(used), 32'd3);

        // Redirect out of range: sticky fault until reset.
        do_reset();
        do_start(32'd0);
        cycle();
        redirect_valid = 1'b1; redirect_addr = 32'd200;
        cycle();
        redirect_valid = 1'b0;
        chk("rfault_fault", 32'(fault), 32'd1);
        chk("rfault_valid", 32'(out_valid), 32'd0);
        start = 1'b1; start_addr = 32'd1;
        for (int i = 0; i < 4; i++) cycle();
        start = 1'b0;
        chk("rfault_sticky", 32'(fault), 32'd1);
        chk("rfault_busy", 32'(busy), 32'd1);
        chk("rfault_valid2", 32'(out_valid), 32'd0);
        do_reset();
        chk_reset_state("rfault_reset");

        // Stop with two entries buffered, then restart at 5.
        do_reset();
        do_start(32'd0);
        for (int i = 0; i < 3; i++) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        cycle();
        chk("stop_busy", 32'(busy), 32'd1);
        chk("stop_pc_hold", imem_addr, 32'd2);
        expect_stream(32'd0, 2);
        drain(8, used);
        chk("stop_drain_cycles", 32'(used), 32'd2);
        chk("stop_empty", 32'(out_valid), 32'd0);
        chk("stop_busy_last", 32'(busy), 32'd1);
        cycle();
        chk("stop_idle", 32'(busy), 32'd0);
        do_start(32'd5);
        cycle();
        expect_stream(32'd5, 1);
        drain(8, used);

        // Stop and redirect together: redirect wins, fetching continues.
        do_reset();
        do_start(32'd0);
        for (int i = 0; i < 3; i++) cycle();
        stop = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'd3;
        cycle();
        stop = 1'b0; redirect_valid = 1'b0;
        chk("both_flush", 32'(out_valid), 32'd0);
        expect_stream(32'd3, 2);
        drain(8, used);
        for (int i = 0; i < 3; i++) cycle();
        chk("both_still_fetch", 32'(busy), 32'd1);
        chk("both_refill", 32'(out_valid), 32'd1);

        // Reset mid-fetch.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk_reset_state("midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the address port of the combinational, word-addressed `instruction_memory`. It holds the program counter and steps it through memory. Each fetched word is captured, tagged with its address, into a 2-entry prefetch buffer, and the buffer presents words to the decode stage over a valid/ready handshake. It also supports start, stop/drain, branch redirect, end-of-memory wrap and out-of-range fault detection.

## Interface
Parameters:
- `DEPTH`, 128: number of words in instruction memory; the PC wraps modulo `DEPTH`.
- `ADDR_W`, 32: width of word addresses.
- `DATA_W`, 32: instruction width.
- `BUF_DEPTH`, 2: prefetch buffer entries. Fixed at 2; the counter and flag logic depend on it.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset. Sampled on `clk`.
- `start` in 1: begin fetching at `start_addr`. Honoured only in IDLE.
- `start_addr` in `ADDR_W`: word address of the first fetch.
- `stop` in 1: cease fetching, drain the buffer, then go to IDLE.
- `redirect_valid` in 1: branch or jump redirect request.
- `redirect_addr` in `ADDR_W`: redirect target word address.
- `imem_addr` out `ADDR_W`: drives the instruction memory address; equals the PC register.
- `imem_data` in `DATA_W`: combinational read data from instruction memory.
- `out_valid` out 1: buffer head holds a valid instruction.
- `out_ready` in 1: consumer accepts the head this cycle.
- `out_instr` out `DATA_W`: instruction at the buffer head.
- `out_pc` out `ADDR_W`: word address of `out_instr`.
- `busy` out 1: state is not IDLE.
- `fault` out 1: a start or redirect target was ≥ `DEPTH`. Sticky until reset.

## Operation
- **States:** IDLE, FETCH, DRAIN, FAULT.
- **Reset** (`reset_n`=0 at an edge) takes effect regardless of state, including mid-fetch or mid-drain:
  - PC=0, so `imem_addr`=0.
  - Buffer empty, `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - `busy`=0, `fault`=0, state IDLE.
- **IDLE:**
  - `start` with `start_addr` < `DEPTH`: PC←`start_addr`, go to FETCH.
  - `start` with `start_addr` ≥ `DEPTH`: go to FAULT.
  - `stop` and `redirect_valid` are ignored.
- **FETCH:** each cycle where buffer count < 2, or count = 2 with a pop this cycle:
  - Write {PC, `imem_data`} into the buffer.
  - PC←PC+1, or 0 when PC = `DEPTH`-1 (wrap).
  - Otherwise PC holds (stall).
- **Priority within FETCH:** redirect > stop > normal fetch.
- **Redirect** (FETCH or DRAIN):
  - Buffer flushed next cycle.
  - A handshake completed in the redirect cycle still counts as consumed.
  - PC←`redirect_addr`. No write occurs in the redirect cycle.
  - State becomes FETCH, even from DRAIN.
  - A target ≥ `DEPTH` goes to FAULT instead.
- **DRAIN:**
  - No buffer writes; PC holds.
  - Go to IDLE in the cycle after the buffer becomes empty.
- **FAULT:**
  - Buffer flushed, `out_valid`=0, `fault`=1, `busy`=1.
  - Exits only via reset.
- **Buffer:**
  - Pop occurs when `out_valid`&`out_ready`.
  - Push and pop in the same cycle keeps the count.
  - Order is strictly FIFO; no entry is dropped except by a flush.
- **Stability:** `out_instr` and `out_pc` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **`imem_addr`:** driven directly from the PC register, so there is no combinational path from inputs to it.
- **Memory read:** `imem_data` is sampled at the same edge that advances the PC.
- **Start latency:** `start` at edge N → first write at edge N+1 → `out_valid`=1 in cycle N+2.
- **Redirect latency:** sampled at edge N → `out_valid`=0 in cycle N+1 → target word valid in cycle N+2.
- **Throughput:** one instruction per cycle with `out_ready` held high.
- **Outputs:** all outputs are registered except `imem_addr`, which is the PC register itself.
- **`start` while busy:** ignored; it is neither queued nor remembered.

## Structure
- **Package `fetch_pkg`:**
  - state enum `fetch_state_t` {IDLE, FETCH, DRAIN, FAULT};
  - `IMEM_DEPTH`=128;
  - the buffer entry struct {pc, instr}.
- **Sub-module `fetch_buffer`:**
  - 2-entry synchronous FIFO with push, pop, flush, count, full and empty.
  - Same `clk` and `reset_n`.
- **Top level:** FSM, PC register and wrap/range checks.

## Test plan
Instruction memory image: word0=0xA00000AA; word k=0xk00000kk for k=1..9.

- **Reset and start:** reset, then `start`, `start_addr`=0, `out_ready`=1 → `out_valid` rises 2 cycles after `start`. Consecutive outputs: (0, 0xA00000AA), (1, 0x10000011), (2, 0x20000022).
- **Backpressure:** `out_ready`=0 from the first valid → count saturates at 2 and PC holds at 2. `out_pc`=0, `out_instr`=0xA00000AA stay stable. Raising `out_ready` yields 0, 1, 2 with no gap or duplicate.
- **Redirect:** in FETCH, `redirect_valid`=1, `redirect_addr`=7 → next cycle `out_valid`=0. The following output is (7, 0x70000077), then (8, 0x80000088).
- **Wrap and fault:** start at 126 → `out_pc` sequence 126, 127, 0, 1 with instruction 0xA00000AA at PC 0. Separately, redirect to 200 → `fault`=1, `out_valid`=0, held until reset.
- **Stop:** `stop` with 2 entries buffered → exactly those 2 are delivered, then `busy` falls. A later `start`, `start_addr`=5 → (5, 0x50000055).
- **Simultaneous and reset events:** `stop` and `redirect_valid` asserted together → the redirect wins and fetching resumes at the target. `reset_n`=0 mid-FETCH → next cycle all outputs are at reset values and state is IDLE.
